// File: rtl/blur_pkg.sv
// Shared definitions for the 3x3 Gaussian blur engine: FSM encoding, kernel
// weights, normalisation shift/rounding and default frame geometry.
package blur_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } blur_state_t;

  localparam int KERNEL_SHIFT = 4;
  localparam int KERNEL_ROUND = 8;
  localparam int SUM_W        = 12;
  localparam int DEF_WIDTH    = 320;
  localparam int DEF_HEIGHT   = 240;

  // Separable 1-2-1 kernel: weight is the product of the row and column taps.
  function automatic int kernel_weight(input int row, input int col);
    return ((row == 1) ? 2 : 1) * ((col == 1) ? 2 : 1);
  endfunction

endpackage

// File: rtl/blur_line_buffer.sv
// DEPTH-deep 8-bit delay line: dout is the value shifted in DEPTH enabled
// shifts ago, realised as a circular buffer with a single read/write pointer.
module blur_line_buffer
  import blur_pkg::*;
#(
  parameter int DEPTH = DEF_WIDTH
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       shift_en,
  input  logic [7:0] din,
  output logic [7:0] dout
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [7:0]       r_mem [DEPTH];
  logic [PTR_W-1:0] r_ptr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr <= '0;
    end else if (shift_en) begin
      r_ptr <= (r_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (shift_en) begin
      r_mem[r_ptr] <= din;
    end
  end

  // The slot about to be overwritten holds the oldest sample.
  assign dout = r_mem[r_ptr];

endmodule

// File: rtl/blur_engine.sv
// Streams a frame from the source BRAM, applies a 3x3 Gaussian blur and writes
// the result to the destination BRAM. Optional feature: BLUR_ENGINE_BYPASS_EN.
module blur_engine
  import blur_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int ADDR_W = 17,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              blur_start,
  output logic [ADDR_W-1:0] src_addr,
  input  logic [7:0]        src_data,
  output logic [ADDR_W-1:0] dst_addr,
  output logic [7:0]        dst_data,
  output logic              dst_we,
  output logic              busy,
  output logic              blur_done
`ifdef BLUR_ENGINE_BYPASS_EN
  ,
  input  logic              bypass
`endif
);

  localparam int N          = WIDTH * HEIGHT;
  localparam int CNT_W      = ADDR_W + 2;
  localparam int COL_W      = $clog2(WIDTH);
  localparam int ROW_W      = $clog2(HEIGHT);
  localparam int IN_FIRST   = RD_LAT;
  localparam int IN_LAST    = RD_LAT + N - 1;
  localparam int CALC_FIRST = RD_LAT + WIDTH + 1;
  localparam int CALC_LAST  = CALC_FIRST + N - 1;
  localparam int LAST_WR    = CALC_LAST + 1;

  blur_state_t       r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_src_addr;
  logic              r_busy;
  logic              r_done;
  logic              r_bypass;

  logic [7:0]        r_win [3][2];
  logic [ADDR_W-1:0] r_pidx;
  logic [ADDR_W-1:0] r_dst_addr;
  logic [7:0]        r_dst_data;
  logic              r_dst_we;
  logic [COL_W-1:0]  r_pcol;
  logic [ROW_W-1:0]  r_prow;

  logic              w_bypass_in;
  logic              w_active;
  logic              w_in_valid;
  logic              w_calc;
  logic              w_border;
  logic [7:0]        w_pix_in;
  logic [7:0]        w_col  [3];
  logic [7:0]        w_tap  [9];
  logic [SUM_W-1:0]  w_term [9];
  logic [SUM_W-1:0]  w_sum;
  logic [7:0]        w_blur;

`ifdef BLUR_ENGINE_BYPASS_EN
  assign w_bypass_in = bypass;
`else
  assign w_bypass_in = 1'b0;
`endif

  // r_cnt counts cycles since t0; read k is issued while r_cnt == k.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_src_addr <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_bypass   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (blur_start) begin
            r_state    <= ST_RUN;
            r_cnt      <= '0;
            r_src_addr <= '0;
            r_busy     <= 1'b1;
            r_bypass   <= w_bypass_in;
          end
        end
        ST_RUN: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(N - 1)) begin
            r_state <= ST_FLUSH;
          end else begin
            r_src_addr <= r_src_addr + ADDR_W'(1);
          end
        end
        ST_FLUSH: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(LAST_WR)) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_active   = (r_state == ST_RUN) || (r_state == ST_FLUSH);
  assign w_in_valid = w_active && (r_cnt >= CNT_W'(IN_FIRST)) && (r_cnt <= CNT_W'(IN_LAST));
  assign w_calc     = w_active && (r_cnt >= CNT_W'(CALC_FIRST)) && (r_cnt <= CNT_W'(CALC_LAST));
  assign w_pix_in   = w_in_valid ? src_data : 8'd0;

  blur_line_buffer #(.DEPTH(WIDTH)) u_line1 (
    .clk      (clk),
    .reset_n  (reset_n),
    .shift_en (w_active),
    .din      (w_pix_in),
    .dout     (w_col[1])
  );

  blur_line_buffer #(.DEPTH(WIDTH)) u_line2 (
    .clk      (clk),
    .reset_n  (reset_n),
    .shift_en (w_active),
    .din      (w_col[1]),
    .dout     (w_col[0])
  );

  assign w_col[2] = w_pix_in;

  // Newest column comes straight from the input so the centre tap r_win[1][1]
  // is pixel p in the same cycle that pixel p+WIDTH+1 arrives.
  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_tap
      localparam int ROW = gi / 3;
      localparam int COL = gi % 3;
      if (COL == 2) begin : g_new
        assign w_tap[gi] = w_col[ROW];
      end else begin : g_reg
        assign w_tap[gi] = r_win[ROW][COL];
      end
      assign w_term[gi] = SUM_W'(w_tap[gi]) * SUM_W'(kernel_weight(ROW, COL));
    end
  endgenerate

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < 9; i++) begin
      w_sum = w_sum + w_term[i];
    end
  end

  assign w_blur   = 8'((w_sum + SUM_W'(KERNEL_ROUND)) >> KERNEL_SHIFT);
  assign w_border = (r_pcol == '0) || (r_pcol == COL_W'(WIDTH - 1)) ||
                    (r_prow == '0) || (r_prow == ROW_W'(HEIGHT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < 3; r++) begin
        r_win[r][0] <= 8'd0;
        r_win[r][1] <= 8'd0;
      end
      r_pidx     <= '0;
      r_dst_addr <= '0;
      r_dst_data <= 8'd0;
      r_dst_we   <= 1'b0;
      r_pcol     <= '0;
      r_prow     <= '0;
    end else begin
      r_dst_we <= w_calc;
      if (w_active) begin
        for (int r = 0; r < 3; r++) begin
          r_win[r][0] <= r_win[r][1];
          r_win[r][1] <= w_col[r];
        end
      end
      if (r_state == ST_IDLE) begin
        r_pidx <= '0;
        r_pcol <= '0;
        r_prow <= '0;
      end else if (w_calc) begin
        r_dst_addr <= r_pidx;
        r_dst_data <= (w_border || r_bypass) ? r_win[1][1] : w_blur;
        r_pidx     <= r_pidx + ADDR_W'(1);
        if (r_pcol == COL_W'(WIDTH - 1)) begin
          r_pcol <= '0;
          r_prow <= r_prow + ROW_W'(1);
        end else begin
          r_pcol <= r_pcol + COL_W'(1);
        end
      end
    end
  end

  assign src_addr  = r_src_addr;
  assign dst_addr  = r_dst_addr;
  assign dst_data  = r_dst_data;
  assign dst_we    = r_dst_we;
  assign busy      = r_busy;
  assign blur_done = r_done;

endmodule

// File: tb/tb_blur_engine.sv
// Self-checking bench for blur_engine on a 4x3 frame: table-driven frames and
// probes, randomized images against a 2-D reference model, reset-abort sequence.
module tb_blur_engine;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int N  = W * H;
  localparam int AW = 4;
  localparam int RL = 1;
  localparam int T_DONE = 1 + N + W + RL + 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          blur_start = 1'b0;
  logic [AW-1:0] src_addr;
  logic [7:0]    src_data = 8'd0;
  logic [AW-1:0] dst_addr;
  logic [7:0]    dst_data;
  logic          dst_we;
  logic          busy;
  logic          blur_done;
`ifdef BLUR_ENGINE_BYPASS_EN
  logic          bypass = 1'b0;
`endif

  always #5 clk = ~clk;

  blur_engine #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .RD_LAT(RL)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .blur_start (blur_start),
    .src_addr   (src_addr),
    .src_data   (src_data),
    .dst_addr   (dst_addr),
    .dst_data   (dst_data),
    .dst_we     (dst_we),
    .busy       (busy),
    .blur_done  (blur_done)
`ifdef BLUR_ENGINE_BYPASS_EN
    ,
    .bypass     (bypass)
`endif
  );

  int img [16];
  always @(posedge clk) src_data <= 8'(img[src_addr]);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit mon_en = 1'b0;
  int c0;
  int wr_addr[$], wr_data[$], wr_cyc[$], done_cyc[$];
  int busy_first, busy_last, busy_cnt;

  always @(negedge clk) begin
    if (mon_en) begin
      if (dst_we) begin
        wr_addr.push_back(int'(dst_addr));
        wr_data.push_back(int'(dst_data));
        wr_cyc.push_back(cyc - c0);
      end
      if (blur_done) done_cyc.push_back(cyc - c0);
      if (busy) begin
        if (busy_cnt == 0) busy_first = cyc - c0;
        busy_last = cyc - c0;
        busy_cnt++;
      end
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: border or bypass copies the source; interior is the rounded 1-2-1 kernel.
  function automatic int ref_pix(input int p, input bit byp);
    int r, c, s, wt;
    r = p / W;
    c = p % W;
    if (byp || r == 0 || r == H - 1 || c == 0 || c == W - 1) return img[p];
    s = 0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++) begin
        wt = ((dr == 0) ? 2 : 1) * ((dc == 0) ? 2 : 1);
        s += wt * img[(r + dr) * W + c + dc];
      end
    return (s + 8) / 16;
  endfunction

  task automatic fill_image(input int kind);
    for (int i = 0; i < 16; i++) begin
      case (kind)
        0:       img[i] = 100;
        1:       img[i] = (i == 5) ? 255 : 0;
        2:       img[i] = (i < N) ? i * 20 : 0;
        default: img[i] = int'($urandom_range(0, 255));
      endcase
    end
  endtask

  task automatic start_capture();
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete(); done_cyc.delete();
    busy_cnt = 0; busy_first = -1; busy_last = -1;
    c0 = cyc;
    mon_en = 1'b1;
  endtask

  task automatic run_frame(input int dup_at, input bit byp);
    @(negedge clk);
    start_capture();
    blur_start = 1'b1;
`ifdef BLUR_ENGINE_BYPASS_EN
    bypass = byp;
`endif
    for (int k = 1; k <= 35; k++) begin
      @(negedge clk);
      blur_start = (k == dup_at);
`ifdef BLUR_ENGINE_BYPASS_EN
      bypass = 1'b0;
`endif
    end
    mon_en = 1'b0;
  endtask

  typedef struct { int kind; int dup_at; bit byp; } vec_t;
  typedef struct { int kind; int addr; int val; } probe_t;
  vec_t   vecs[$];
  probe_t probes[$];

  task automatic check_frame(input string tag, input int kind, input bit byp);
    int got;
    check({tag, " write_count"}, wr_addr.size(), N);
    for (int i = 0; i < wr_addr.size() && i < N; i++) begin
      check($sformatf("%s w%0d addr", tag, i), wr_addr[i], i);
      check($sformatf("%s w%0d cycle", tag, i), wr_cyc[i], 1 + i + W + RL + 2);
      check($sformatf("%s w%0d data", tag, i), wr_data[i], ref_pix(i, byp));
    end
    check({tag, " done_count"}, done_cyc.size(), 1);
    check({tag, " done_cycle"}, (done_cyc.size() > 0) ? done_cyc[0] : -1, T_DONE);
    check({tag, " busy_first"}, busy_first, 1);
    check({tag, " busy_last"}, busy_last, T_DONE);
    check({tag, " busy_cycles"}, busy_cnt, T_DONE);
    foreach (probes[j]) begin
      if (probes[j].kind == kind && !byp) begin
        got = -1;
        foreach (wr_addr[m]) if (wr_addr[m] == probes[j].addr) got = wr_data[m];
        check($sformatf("%s probe addr %0d", tag, probes[j].addr), got, probes[j].val);
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " src_addr"}, int'(src_addr), 0);
    check({tag, " dst_addr"}, int'(dst_addr), 0);
    check({tag, " dst_data"}, int'(dst_data), 0);
    check({tag, " dst_we"}, int'(dst_we), 0);
    check({tag, " busy"}, int'(busy), 0);
    check({tag, " blur_done"}, int'(blur_done), 0);
  endtask

  initial begin
    vecs.push_back('{0, -1, 1'b0});
    vecs.push_back('{1, -1, 1'b0});
    vecs.push_back('{0,  5, 1'b0});
    vecs.push_back('{2, -1, 1'b0});
    vecs.push_back('{3, -1, 1'b0});
    vecs.push_back('{3, -1, 1'b0});
    vecs.push_back('{3, 12, 1'b0});
`ifdef BLUR_ENGINE_BYPASS_EN
    vecs.push_back('{1, -1, 1'b1});
`endif
    probes.push_back('{0, 0, 100});
    probes.push_back('{0, 5, 100});
    probes.push_back('{0, 11, 100});
    probes.push_back('{1, 5, 64});
    probes.push_back('{1, 6, 32});
    probes.push_back('{1, 0, 0});
    probes.push_back('{1, 1, 0});
    probes.push_back('{1, 10, 0});
    foreach (probes[j]) if (probes[j].kind == 1 && probes[j].addr == 1) begin end
    for (int a = 0; a < N; a++)
      if (a / W == 0 || a / W == H - 1 || a % W == 0 || a % W == W - 1)
        probes.push_back('{2, a, a * 20});
    probes.push_back('{2, 5, 100});
    probes.push_back('{2, 6, 120});

    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[v]) begin
      fill_image(vecs[v].kind);
      run_frame(vecs[v].dup_at, vecs[v].byp);
      check_frame($sformatf("frame%0d", v), vecs[v].kind, vecs[v].byp);
      $display("frame %0d kind=%0d dup=%0d bypass=%0d writes=%0d done_at=%0d",
               v, vecs[v].kind, vecs[v].dup_at, vecs[v].byp, wr_addr.size(),
               (done_cyc.size() > 0) ? done_cyc[0] : -1);
    end

    // Abort mid-frame: reset at cycle 10 clears outputs at once and kills the frame.
    fill_image(0);
    @(negedge clk);
    start_capture();
    blur_start = 1'b1;
    for (int k = 1; k <= 35; k++) begin
      @(negedge clk);
      blur_start = 1'b0;
      if (k == 10) begin
        #2 reset_n = 1'b0;
        #1 check_idle_outputs("abort");
      end
      if (k == 13) reset_n = 1'b1;
    end
    mon_en = 1'b0;
    check("abort writes_before_reset", wr_addr.size(), 3);
    check("abort done_count", done_cyc.size(), 0);
    $display("abort frame writes=%0d done_pulses=%0d", wr_addr.size(), done_cyc.size());

    run_frame(-1, 1'b0);
    check_frame("after_abort", 0, 1'b0);
    $display("frame after abort writes=%0d done_at=%0d", wr_addr.size(),
             (done_cyc.size() > 0) ? done_cyc[0] : -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
